key_conditioner: RTL and testbench

- Upstream input stage for the switch/pushbutton calculator datapath.
- Synchronises and debounces the active-low pushbuttons, then emits clean single-cycle press and release strobes plus a debounced held level.
- The downstream calculator register stage uses these strobes as load/clear enables on the system clock, replacing raw button edges.

---
 rtl/key_conditioner.sv | 76 +++++++
 tb/tb_key_conditioner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// ============================================================================
// Module   : key_conditioner
// Brief    : Synchronise and debounce active-low pushbuttons into a held
//            level plus one-cycle press/release strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_conditioner #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    localparam int              CNT_W      = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            logic             r_sync1;
            logic             r_sync2;
            logic [CNT_W-1:0] r_cnt;
            logic             r_held;
            logic             r_press;
            logic             r_release;
            logic             w_sample;

            assign w_sample = ~r_sync2;

            // Synchroniser idles at "released" so a key held through reset
            // is seen as a fresh press once reset lifts.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sync1   <= 1'b1;
                    r_sync2   <= 1'b1;
                    r_cnt     <= '0;
                    r_held    <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_sync1 <= key_n[gi];
                    r_sync2 <= r_sync1;
                    if (w_sample == r_held) begin
                        r_cnt     <= '0;
                        r_press   <= 1'b0;
                        r_release <= 1'b0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_held    <= w_sample;
                        r_cnt     <= '0;
                        r_press   <= w_sample;
                        r_release <= ~w_sample;
                    end else begin
                        r_cnt     <= r_cnt + C_CNT_ONE;
                        r_press   <= 1'b0;
                        r_release <= 1'b0;
                    end
                end
            end

            assign key_held[gi]    = r_held;
            assign key_press[gi]   = r_press;
            assign key_release[gi] = r_release;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// ============================================================================
// Module   : tb_key_conditioner
// Brief    : Self-checking bench for key_conditioner (DEBOUNCE 4 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_key_conditioner;

    localparam int NK = 2;
    localparam int DA = 4;
    localparam int DB = 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_n = '1;
    logic [NK-1:0] held_a, press_a, rel_a;
    logic [NK-1:0] held_b, press_b, rel_b;

    key_conditioner #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DA)) dut_a (
        .clk(clk), .rst_n(rst_n), .key_n(key_n),
        .key_held(held_a), .key_press(press_a), .key_release(rel_a)
    );

    key_conditioner #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB)) dut_b (
        .clk(clk), .rst_n(rst_n), .key_n(key_n),
        .key_held(held_b), .key_press(press_b), .key_release(rel_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a key is accepted once the last D synchronised
    // samples all disagree with the held level.
    bit m_s1    [2][NK];
    bit m_s2    [2][NK];
    bit m_held  [2][NK];
    bit m_press [2][NK];
    bit m_rel   [2][NK];
    bit m_win   [2][NK][$];

    function automatic int dcyc(int inst);
        return (inst == 0) ? DA : DB;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NK; k++) begin
                if (!rst_n) begin
                    m_s1[i][k] = 1'b1;  m_s2[i][k] = 1'b1;
                    m_held[i][k] = 1'b0; m_press[i][k] = 1'b0; m_rel[i][k] = 1'b0;
                    m_win[i][k].delete();
                end else begin
                    bit smp;
                    bit all_diff;
                    smp = ~m_s2[i][k];
                    m_s2[i][k] = m_s1[i][k];
                    m_s1[i][k] = key_n[k];
                    m_press[i][k] = 1'b0;
                    m_rel[i][k]   = 1'b0;
                    m_win[i][k].push_back(smp);
                    if (m_win[i][k].size() > dcyc(i)) void'(m_win[i][k].pop_front());
                    all_diff = (m_win[i][k].size() == dcyc(i));
                    foreach (m_win[i][k][j]) if (m_win[i][k][j] == m_held[i][k]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_held[i][k]  = smp;
                        m_press[i][k] = smp;
                        m_rel[i][k]   = ~smp;
                        m_win[i][k].delete();
                    end
                end
            end
        end
    endtask

    function automatic logic [NK-1:0] pk(int inst, int which);
        logic [NK-1:0] v;
        v = '0;
        for (int k = 0; k < NK; k++)
            v[k] = (which == 0) ? m_held[inst][k] : (which == 1) ? m_press[inst][k] : m_rel[inst][k];
        return v;
    endfunction

    task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge; instance B (DEBOUNCE=1) is always tracked by the model.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("b_held",    held_b,  pk(1, 0));
        chk("b_press",   press_b, pk(1, 1));
        chk("b_release", rel_b,   pk(1, 2));
    endtask

    task automatic chk_a_model();
        chk("a_held",    held_a,  pk(0, 0));
        chk("a_press",   press_a, pk(0, 1));
        chk("a_release", rel_a,   pk(0, 2));
    endtask

    typedef struct {
        logic          rst_n;
        logic [NK-1:0] key_n;
        logic [NK-1:0] held;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
    } vec_t;

    vec_t tbl[$];

    task automatic add_n(input int n, input logic r, input logic [NK-1:0] k,
                         input logic [NK-1:0] h, input logic [NK-1:0] p, input logic [NK-1:0] rl);
        vec_t v;
        v.rst_n = r; v.key_n = k; v.held = h; v.press = p; v.rel = rl;
        repeat (n) tbl.push_back(v);
    endtask

    initial begin
        // Reset, idle, then key0 press and release
        add_n(2,  1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
        add_n(20, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
        add_n(5,  1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
        add_n(1,  1'b1, 2'b10, 2'b01, 2'b01, 2'b00);
        add_n(3,  1'b1, 2'b10, 2'b01, 2'b00, 2'b00);
        add_n(5,  1'b1, 2'b11, 2'b01, 2'b00, 2'b00);
        add_n(1,  1'b1, 2'b11, 2'b00, 2'b00, 2'b01);
        add_n(3,  1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
        // Three-cycle glitch on key0: rejected
        add_n(3,  1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
        add_n(8,  1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
        // Both keys together
        add_n(5,  1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        add_n(1,  1'b1, 2'b00, 2'b11, 2'b11, 2'b00);
        add_n(2,  1'b1, 2'b00, 2'b11, 2'b00, 2'b00);
        add_n(5,  1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
        add_n(1,  1'b1, 2'b11, 2'b00, 2'b00, 2'b11);
        add_n(3,  1'b1, 2'b11, 2'b00, 2'b00, 2'b00);

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n;
            key_n = tbl[i].key_n;
            step();
            chk("tbl_held",    held_a,  tbl[i].held);
            chk("tbl_press",   press_a, tbl[i].press);
            chk("tbl_release", rel_a,   tbl[i].rel);
        end

        // Bounce on key1, then steady press
        begin
            logic [NK-1:0] bounce [4];
            bounce[0] = 2'b01; bounce[1] = 2'b11; bounce[2] = 2'b01; bounce[3] = 2'b11;
            for (int b = 0; b < 4; b++) begin
                key_n = bounce[b];
                step();
                chk("bounce_quiet", press_a | rel_a | held_a, 2'b00);
            end
        end
        key_n = 2'b01;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk("bounce_press", press_a, (e == 6) ? 2'b10 : 2'b00);
            chk("bounce_held",  held_a,  (e >= 6) ? 2'b10 : 2'b00);
        end
        key_n = 2'b11;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk("bounce_release", rel_a, (e == 6) ? 2'b10 : 2'b00);
        end

        // Reset abandons an in-progress count; key held through reset
        key_n = 2'b10;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk("prereset_quiet", press_a | held_a, 2'b00);
        end
        rst_n = 1'b0;
        for (int e = 1; e <= 2; e++) begin
            step();
            chk("inreset_quiet", press_a | held_a | rel_a, 2'b00);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk("postreset_press", press_a, (e == 6) ? 2'b01 : 2'b00);
            chk("postreset_held",  held_a,  (e >= 6) ? 2'b01 : 2'b00);
        end

        // Randomised traffic against the model, both instances
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 7) == 0) key_n[k] = ~key_n[k];
            rst_n = ($urandom_range(0, 299) != 0);
            step();
            chk_a_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
